// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate backed by a word-organised SRAM built from four byte lanes.
// Handles byte/half/word single and burst transfers. Illegal size, misaligned or
// out-of-range accesses get a two-cycle ERROR response.
// Optional feature: define AHB_SLV_WAIT_STATES_EN to insert WAIT_STATES wait cycles
// in front of every error-free NONSEQ transfer. SEQ beats stay zero-wait.
module ahb_lite_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES  = 33'(MEM_WORDS) * 33'd4;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state_reg, state_next;

    // Captured address phase of the transfer that currently owns the data phase
    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       lo_reg;
    logic [1:0]       size_reg;
    logic             write_reg;

    // Write-to-read forwarding: lanes that were written on the same edge the read was captured
    logic [3:0]       fwd_mask_reg;
    logic [31:0]      fwd_data_reg;

    logic             ready_int;
    logic             accept;
    logic             addr_err;
    logic             commit;
    logic             rd_en;
    logic [IDX_W-1:0] haddr_idx;
    logic [3:0]       lane_mask;
    logic [31:0]      rd_word;

    // HBURST is informational only. HTRANS[0] matters only when wait states are enabled.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    // Active byte lanes, little-endian, for a legal size/offset pair
    function automatic logic [3:0] lanes_for(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lanes_for = 4'b0001 << lo;
            2'b01:   lanes_for = lo[1] ? 4'b1100 : 4'b0011;
            default: lanes_for = 4'b1111;
        endcase
    endfunction

    assign ready_int = (state_reg != S_WAIT) && (state_reg != S_ERR1);
    assign HREADY    = ready_int;
    assign accept    = HSEL && ready_int && HTRANS[1];
    assign haddr_idx = HADDR[IDX_W+1:2];
    assign lane_mask = lanes_for(size_reg, lo_reg);
    // A write lands at the end of its DATA cycle unless reset aborts it.
    assign commit    = (state_reg == S_DATA) && write_reg && !HRESET;
    assign rd_en     = accept && !HRESET;

`ifdef AHB_SLV_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             use_wait;
    assign use_wait = (WAIT_STATES > 0) && (HTRANS == 2'b10);
`endif

    // Address-phase legality check: size, alignment and range
    always_comb begin
        addr_err = 1'b0;
        if (HSIZE > 3'b010)
            addr_err = 1'b1;
        if ((HSIZE == 3'b001) && HADDR[0])
            addr_err = 1'b1;
        if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
            addr_err = 1'b1;
        if ({1'b0, HADDR} >= MEM_BYTES)
            addr_err = 1'b1;
    end

    // Next-state and response decode
    always_comb begin
        state_next = state_reg;
        HRESP      = RESP_OKAY;
`ifdef AHB_SLV_WAIT_STATES_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            S_WAIT: begin
`ifdef AHB_SLV_WAIT_STATES_EN
                if (cnt_reg == '0)
                    state_next = S_DATA;
                else
                    cnt_next = cnt_reg - 1'b1;
`else
                state_next = S_DATA;
`endif
            end
            S_ERR1: begin
                HRESP      = RESP_ERROR;
                state_next = S_ERR2;
            end
            default: begin
                if (state_reg == S_ERR2)
                    HRESP = RESP_ERROR;
                if (accept) begin
                    if (addr_err)
                        state_next = S_ERR1;
`ifdef AHB_SLV_WAIT_STATES_EN
                    else if (use_wait) begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end
`endif
                    else
                        state_next = S_DATA;
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    // State register and address-phase capture
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            lo_reg       <= 2'b00;
            size_reg     <= 2'b00;
            write_reg    <= 1'b0;
            fwd_mask_reg <= 4'b0000;
            fwd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                idx_reg      <= haddr_idx;
                lo_reg       <= HADDR[1:0];
                size_reg     <= HSIZE[1:0];
                write_reg    <= HWRITE;
                fwd_mask_reg <= (commit && (haddr_idx == idx_reg)) ? lane_mask : 4'b0000;
                fwd_data_reg <= HWDATA;
            end
        end
    end

`ifdef AHB_SLV_WAIT_STATES_EN
    // Wait-cycle countdown
    always_ff @(posedge HCLK) begin
        if (HRESET)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [MEM_WORDS];
            logic [7:0] rd_lane_reg;

            // Byte-lane RAM: masked write at the end of DATA, registered read on accept
            always_ff @(posedge HCLK) begin
                if (commit && lane_mask[gi])
                    mem_lane[idx_reg] <= HWDATA[gi*8 +: 8];
                if (rd_en)
                    rd_lane_reg <= mem_lane[haddr_idx];
            end

            assign rd_word[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

    // Read data: active lanes only, with freshly written lanes forwarded
    always_comb begin
        HRDATA = '0;
        if ((state_reg == S_DATA) && !write_reg) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i])
                    HRDATA[i*8 +: 8] = fwd_mask_reg[i] ? fwd_data_reg[i*8 +: 8] : rd_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomised, self-checking bench for ahb_lite_sram_slave. The master is driven from
// a transfer-level model of the slave (byte-addressed memory plus response timing),
// and a compare process checks every cycle. Honours AHB_SLV_WAIT_STATES_EN when defined.
module tb_ahb_lite_sram_slave;

    localparam int MEM_WORDS   = 1024;
    localparam int WAIT_STATES = 2;
    localparam int MEM_BYTES   = MEM_WORDS * 4;
`ifdef AHB_SLV_WAIT_STATES_EN
    localparam int WS_MODEL = WAIT_STATES;
`else
    localparam int WS_MODEL = 0;
`endif

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    ahb_lite_sram_slave #(
        .MEM_WORDS  (MEM_WORDS),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .HSEL  (HSEL),
        .HADDR (HADDR),
        .HWRITE(HWRITE),
        .HSIZE (HSIZE),
        .HBURST(HBURST),
        .HTRANS(HTRANS),
        .HWDATA(HWDATA),
        .HREADY(HREADY),
        .HRESP (HRESP),
        .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
        bit          lit_chk;
        logic [31:0] lit_val;
    } xfer_t;

    typedef struct {
        bit          chk;
        bit          chk_data;
        logic        ready;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          lit_chk;
        logic [31:0] lit_val;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model_mem [MEM_BYTES];
    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;

    // Model of the transfer owning the data phase and of the pending address phase
    xfer_t a_cur;
    xfer_t d_cur;
    bit    d_valid = 0;
    bit    d_err   = 0;
    int    d_wait  = 0;
    int    d_errph = 0;

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic write,
                                 input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata);
        xfer_t t;
        t.sel = sel; t.trans = trans; t.write = write; t.addr = addr; t.size = size;
        t.burst = 3'b000; t.wdata = wdata; t.lit_chk = 0; t.lit_val = '0;
        return t;
    endfunction

    function automatic xfer_t mk_rd_lit(input logic [31:0] addr, input logic [2:0] size,
                                        input logic [31:0] lit);
        xfer_t t;
        t = mk(1'b1, 2'b10, 1'b0, addr, size, 32'h0);
        t.lit_chk = 1;
        t.lit_val = lit;
        return t;
    endfunction

    function automatic bit is_err(input xfer_t t);
        if (t.size > 3'd2) return 1;
        if ((t.addr % (32'd1 << t.size)) != 0) return 1;
        if (t.addr >= MEM_BYTES) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input xfer_t t);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < (1 << t.size); b++) begin
            int unsigned a = t.addr + b;
            v[(a % 4) * 8 +: 8] = model_mem[a];
        end
        return v;
    endfunction

    function automatic void model_write(input xfer_t t);
        for (int b = 0; b < (1 << t.size); b++) begin
            int unsigned a = t.addr + b;
            model_mem[a] = t.wdata[(a % 4) * 8 +: 8];
        end
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t t;
        int unsigned w;
        t = mk(1'b0, 2'b00, 1'b0, 32'h0, 3'b010, $urandom);
        if ($urandom_range(0, 99) < 12) begin
            t.sel   = 1'($urandom_range(0, 1));
            t.trans = 2'($urandom_range(0, 3));
            if (t.sel) t.trans[1] = 1'b0;
            return t;
        end
        t.sel   = 1'b1;
        t.trans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        t.write = 1'($urandom_range(0, 1));
        t.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        w = $urandom_range(0, 67);
        if (w >= 64) w = MEM_WORDS - 4 + (w - 64);
        t.addr = w * 4;
        if ($urandom_range(0, 4) == 0)
            t.addr = t.addr + $urandom_range(0, 3);
        else if (t.size <= 3'd2)
            t.addr = t.addr + ($urandom_range(0, 3) & ~((32'd1 << t.size) - 1));
        if ($urandom_range(0, 24) == 0)
            t.addr = MEM_BYTES + ($urandom_range(0, 16) * 4);
        return t;
    endfunction

    // One bus cycle: derive the expected response, drive the bus, advance the model
    task automatic step(output bit accepted);
        exp_t e;
        e = '{default: 0};
        e.chk = 1;
        e.cyc = cyc_n;
        if (!d_valid) begin
            e.ready = 1'b1; e.resp = 2'b00;
        end else if (d_err) begin
            e.ready = (d_errph == 2); e.resp = 2'b01;
        end else if (d_wait > 0) begin
            e.ready = 1'b0; e.resp = 2'b00; e.rdata = 32'h0; e.chk_data = 1;
        end else begin
            e.ready = 1'b1; e.resp = 2'b00;
            if (!d_cur.write) begin
                e.chk_data = 1;
                e.rdata    = model_read(d_cur);
                e.lit_chk  = d_cur.lit_chk;
                e.lit_val  = d_cur.lit_val;
            end
        end
        HSEL   = a_cur.sel;
        HTRANS = a_cur.trans;
        HWRITE = a_cur.write;
        HADDR  = a_cur.addr;
        HSIZE  = a_cur.size;
        HBURST = a_cur.burst;
        HWDATA = d_valid ? d_cur.wdata : $urandom;
        exp_q.push_back(e);
        if (e.ready && d_valid)
            $display("xfer cyc=%0d %s addr=%h size=%0d resp=%s data=%h", cyc_n,
                     d_cur.write ? "WR" : "RD", d_cur.addr, d_cur.size,
                     d_err ? "ERROR" : "OKAY", d_cur.write ? d_cur.wdata : e.rdata);
        @(posedge HCLK);
        accepted = e.ready;
        if (e.ready) begin
            if (d_valid && !d_err && d_cur.write)
                model_write(d_cur);
            d_valid = a_cur.sel && a_cur.trans[1];
            if (d_valid) begin
                d_cur   = a_cur;
                d_err   = is_err(a_cur);
                d_errph = 1;
                d_wait  = (!d_err && (a_cur.trans == 2'b10)) ? WS_MODEL : 0;
            end
        end else begin
            if (d_err) d_errph = 2;
            else       d_wait  = d_wait - 1;
        end
        #1;
        cyc_n++;
    endtask

    // Present an address phase and hold it until the model says it is taken
    task automatic issue(input xfer_t t);
        bit acc;
        a_cur = t;
        for (int k = 0; k < 64; k++) begin
            step(acc);
            if (acc) return;
        end
    endtask

    // Hold reset; outputs must read as reset values from the second cycle on
    task automatic do_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{default: 0};
            e.chk = (i > 0); e.chk_data = 1; e.ready = 1'b1; e.resp = 2'b00; e.rdata = 32'h0;
            e.cyc = cyc_n;
            HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWDATA = $urandom;
            exp_q.push_back(e);
            @(posedge HCLK);
            #1;
            cyc_n++;
        end
        HRESET  = 1'b0;
        d_valid = 0;
        a_cur   = mk(1'b0, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0);
    endtask

    // Compare process: checks DUT outputs against the model every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    total++;
                    if (HREADY !== e.ready) begin
                        bad++;
                        $display("FAIL cyc=%0d hready got=%b want=%b", e.cyc, HREADY, e.ready);
                    end
                    total++;
                    if (HRESP !== e.resp) begin
                        bad++;
                        $display("FAIL cyc=%0d hresp got=%b want=%b", e.cyc, HRESP, e.resp);
                    end
                    if (e.chk_data) begin
                        total++;
                        if (HRDATA !== e.rdata) begin
                            bad++;
                            $display("FAIL cyc=%0d hrdata got=%h want=%h", e.cyc, HRDATA, e.rdata);
                        end
                    end
                    if (e.lit_chk) begin
                        total++;
                        if (HRDATA !== e.lit_val) begin
                            bad++;
                            $display("FAIL cyc=%0d lit_rdata got=%h want=%h", e.cyc, HRDATA, e.lit_val);
                        end
                        total++;
                        if (e.rdata !== e.lit_val) begin
                            bad++;
                            $display("FAIL cyc=%0d model_pin got=%h want=%h", e.cyc, e.rdata, e.lit_val);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t t;
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
        HSIZE = 3'b010; HBURST = 3'b000; HWDATA = '0;
        a_cur = mk(1'b0, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0);
        @(posedge HCLK);
        #1;

        // Reset, then idle/busy/unselected cycles
        do_reset(2);
        issue(mk(1'b1, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0));
        issue(mk(1'b1, 2'b01, 1'b1, 32'h4, 3'b010, 32'h0));
        issue(mk(1'b0, 2'b10, 1'b1, 32'h8, 3'b010, 32'h0));
        issue(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0));

        // Fill the regions used by random traffic with known words
        for (int w = 0; w < 64; w++)
            issue(mk(1'b1, 2'b10, 1'b1, 32'(w * 4), 3'b010, $urandom));
        for (int w = MEM_WORDS - 4; w < MEM_WORDS; w++)
            issue(mk(1'b1, 2'b10, 1'b1, 32'(w * 4), 3'b010, $urandom));

        // Word write then back-to-back read of the same word
        issue(mk(1'b1, 2'b10, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF));
        issue(mk_rd_lit(32'h10, 3'b010, 32'hDEADBEEF));

        // Byte and half lanes
        issue(mk(1'b1, 2'b10, 1'b1, 32'h20, 3'b010, 32'h00000000));
        issue(mk(1'b1, 2'b10, 1'b1, 32'h23, 3'b000, 32'hAA000000));
        issue(mk(1'b1, 2'b10, 1'b1, 32'h20, 3'b001, 32'h00001234));
        issue(mk_rd_lit(32'h20, 3'b010, 32'hAA001234));
        issue(mk_rd_lit(32'h21, 3'b000, 32'h00001200));
        issue(mk_rd_lit(32'h22, 3'b001, 32'hAA000000));

        // Error cases; the errored write must leave memory untouched
        issue(mk(1'b1, 2'b10, 1'b1, 32'h22, 3'b010, 32'hFFFFFFFF));
        issue(mk(1'b1, 2'b10, 1'b0, 32'(MEM_BYTES), 3'b010, 32'h0));
        issue(mk(1'b1, 2'b10, 1'b0, 32'h20, 3'b011, 32'h0));
        issue(mk_rd_lit(32'h20, 3'b010, 32'hAA001234));

        // INCR4 write burst and readback
        for (int i = 0; i < 4; i++) begin
            t = mk(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b1, 32'(32'h40 + i * 4), 3'b010, 32'(32'h11110000 + i));
            t.burst = 3'b011;
            issue(t);
        end
        for (int i = 0; i < 4; i++) begin
            t = mk_rd_lit(32'(32'h40 + i * 4), 3'b010, 32'(32'h11110000 + i));
            t.trans = (i == 0) ? 2'b10 : 2'b11;
            t.burst = 3'b011;
            issue(t);
        end

        // Randomised traffic
        for (int n = 0; n < 400; n++)
            issue(rand_xfer());

        // Reset during the first data-phase cycle of a write aborts it
        issue(mk(1'b1, 2'b10, 1'b1, 32'h50, 3'b010, 32'h11223344));
        issue(mk(1'b1, 2'b10, 1'b1, 32'h50, 3'b010, 32'h55667788));
        do_reset(2);
        issue(mk_rd_lit(32'h50, 3'b010, 32'h11223344));
        for (int i = 0; i < 3; i++)
            issue(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0));

        @(negedge HCLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
